// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch-stage types and constants
// Purpose: next-PC select codes (shared with the control unit), fetch FSM
//   state encoding, instruction width and a word-alignment helper.
// Ports: none (package).
package instr_fetch_unit_pkg;

  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    NEXT_SEQ  = 2'b00,
    NEXT_JALR = 2'b01,
    NEXT_JAL  = 2'b10,
    NEXT_BR   = 2'b11
  } next_sel_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10,
    S_HALT = 2'b11
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch-stage bus bundle (imem + decode side)
// Purpose: groups the instruction-memory request/response signals and the
//   decode/execute handshake of the fetch stage.
// Modports:
//   master - fetch unit: drives imem_req_o/imem_addr_o, instr_valid_o,
//            instr_o, pc_o, pc_plus4_o, misalign_o; receives imem_gnt_i,
//            imem_rvalid_i, imem_rdata_i, instr_ready_i, next_sel_i,
//            branch_taken_i, target_i.
//   slave  - memory / decode / execute side, directions mirrored.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [ILEN-1:0] imem_rdata_i;

  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [ILEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus4_o;

  logic [1:0]      next_sel_i;
  logic            branch_taken_i;
  logic [XLEN-1:0] target_i;
  logic            misalign_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output instr_valid_o, instr_o, pc_o, pc_plus4_o, misalign_o,
    input  instr_ready_i, next_sel_i, branch_taken_i, target_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  instr_valid_o, instr_o, pc_o, pc_plus4_o, misalign_o,
    output instr_ready_i, next_sel_i, branch_taken_i, target_i
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// rtl/instr_fetch_unit_next_pc_calc.sv - combinational next-PC selection
// Purpose: selects the PC that follows an accepted instruction and flags a
//   non-word-aligned result.
// Ports:
//   pc_i           in  XLEN  address of the instruction being accepted
//   next_sel_i     in  2     seq / jalr / jal / branch select
//   branch_taken_i in  1     branch outcome (branch select only)
//   target_i       in  XLEN  jump/branch target
//   pc_plus4_o     out XLEN  pc_i + 4, modulo 2^XLEN
//   nxt_o          out XLEN  selected next PC
//   misalign_o     out 1     nxt_o is not word aligned
module instr_fetch_unit_next_pc_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      next_sel_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] nxt_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  // Plain truncating add: 0xFFFF_FFFC + 4 wraps to 0 with no flag.
  assign pc_plus4_o = pc_i + FOUR;

  always_comb begin
    nxt_o = pc_plus4_o;
    unique case (next_sel_e'(next_sel_i))
      NEXT_SEQ:  nxt_o = pc_plus4_o;
      // jalr clears bit 0 only; bit 1 may still be set and is caught below.
      NEXT_JALR: nxt_o = {target_i[XLEN-1:1], 1'b0};
      NEXT_JAL:  nxt_o = target_i;
      NEXT_BR:   nxt_o = branch_taken_i ? target_i : pc_plus4_o;
      default:   nxt_o = pc_plus4_o;
    endcase
  end

  assign misalign_o = !is_word_aligned(nxt_o[1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC owner, single-outstanding imem fetch
// Purpose: issues one instruction-memory request at a time, holds the returned
//   word for decode until accepted, then advances the PC using the control
//   unit's select and the execute stage's branch outcome / target. A
//   misaligned next PC halts fetch until reset.
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous active-low reset
//   bus   master modport of instr_fetch_unit_if (imem request/response,
//         decode handshake, next-PC controls, misalign pulse)
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] nxt_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            nxt_misalign;

  instr_fetch_unit_next_pc_calc #(
    .XLEN(XLEN)
  ) u_next_pc_calc (
    .pc_i          (pc_q),
    .next_sel_i    (bus.next_sel_i),
    .branch_taken_i(bus.branch_taken_i),
    .target_i      (bus.target_i),
    .pc_plus4_o    (pc_plus4),
    .nxt_o         (nxt_pc),
    .misalign_o    (nxt_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = 1'b0;
    unique case (state_q)
      // req_q is low for the reset cycle even though state is S_REQ, so a
      // gnt seen then is not a grant of any request.
      S_REQ: begin
        if (req_q && bus.imem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid_i) begin
          instr_d = bus.imem_rdata_i;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready_i) begin
          if (nxt_misalign) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d    = nxt_pc;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    // Outputs are registered copies of the next-state decode.
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_req_o    = req_q;
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pc_plus4;
  assign bus.misalign_o    = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_pc;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next PC straight from the select rules, in 64-bit arithmetic reduced mod 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] sel,
                                             input logic tk, input logic [31:0] tgt);
    logic [63:0] seq;
    seq = (64'(pc) + 64'd4) % 64'h1_0000_0000;
    case (sel)
      2'd0: return seq[31:0];
      2'd1: return tgt - (tgt % 2);
      2'd2: return tgt;
      default: return tk ? tgt : seq[31:0];
    endcase
  endfunction

  task automatic idle_inputs();
    bus.imem_gnt_i     = 1'b0;
    bus.imem_rvalid_i  = 1'b0;
    bus.imem_rdata_i   = $urandom;
    bus.instr_ready_i  = 1'b0;
    bus.next_sel_i     = 2'($urandom_range(0, 3));
    bus.branch_taken_i = 1'($urandom_range(0, 1));
    bus.target_i       = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_req",      bus.imem_req_o,    0);
    check("rst_valid",    bus.instr_valid_o, 0);
    check("rst_instr",    bus.instr_o,       0);
    check("rst_pc",       bus.pc_o,          RESET_PC);
    check("rst_misalign", bus.misalign_o,    0);
    rst_n  = 1'b1;
    exp_pc = RESET_PC;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (bus.imem_req_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_timeout", bus.imem_req_o, 1);
  endtask

  // Request phase up to and including the grant; returns in S_WAIT.
  task automatic grant_phase(input int gd);
    wait_req();
    check("req_addr", bus.imem_addr_o, exp_pc);
    repeat (gd) begin
      bus.imem_gnt_i = 1'b0;
      @(negedge clk);
      check("gnt_wait_req",  bus.imem_req_o,  1);
      check("gnt_wait_addr", bus.imem_addr_o, exp_pc);
    end
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    bus.imem_gnt_i = 1'b0;
    check("wait_noreq", bus.imem_req_o, 0);
  endtask

  // One full fetch. Returns 1 if the accept halted on a misaligned target.
  task automatic fetch_one(input int gd, input int rd, input int hold, input logic [1:0] sel,
                           input logic tk, input logic [31:0] tgt, input logic [31:0] word,
                           output bit halted);
    logic [31:0] nxt;
    halted = 0;
    grant_phase(gd);
    repeat (rd) begin
      @(negedge clk);
      check("wait_valid", bus.instr_valid_o, 0);
      check("wait_req2",  bus.imem_req_o,    0);
    end
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = word;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = $urandom;
    check("hold_valid", bus.instr_valid_o, 1);
    check("hold_instr", bus.instr_o,       word);
    check("hold_pc",    bus.pc_o,          exp_pc);
    check("hold_pc4",   bus.pc_plus4_o,    model_next(exp_pc, 2'd0, 1'b0, 32'd0));
    repeat (hold) begin
      bus.instr_ready_i = 1'b0;
      bus.next_sel_i    = 2'($urandom_range(0, 3));
      bus.target_i      = $urandom;
      @(negedge clk);
      check("bp_valid", bus.instr_valid_o, 1);
      check("bp_instr", bus.instr_o,       word);
      check("bp_pc",    bus.pc_o,          exp_pc);
      check("bp_req",   bus.imem_req_o,    0);
    end
    bus.instr_ready_i  = 1'b1;
    bus.next_sel_i     = sel;
    bus.branch_taken_i = tk;
    bus.target_i       = tgt;
    @(negedge clk);
    idle_inputs();
    nxt = model_next(exp_pc, sel, tk, tgt);
    if (nxt % 4 != 0) begin
      halted = 1;
      check("mis_pulse", bus.misalign_o,    1);
      check("mis_valid", bus.instr_valid_o, 0);
      check("mis_req",   bus.imem_req_o,    0);
      check("mis_pc",    bus.pc_o,          exp_pc);
      repeat (4) begin
        bus.imem_gnt_i    = 1'b1;
        bus.instr_ready_i = 1'b1;
        @(negedge clk);
        check("halt_pulse_end", bus.misalign_o,    0);
        check("halt_req",       bus.imem_req_o,    0);
        check("halt_valid",     bus.instr_valid_o, 0);
      end
      idle_inputs();
    end else begin
      check("acc_misalign", bus.misalign_o,    0);
      check("acc_req",      bus.imem_req_o,    1);
      check("acc_addr",     bus.imem_addr_o,   nxt);
      exp_pc = nxt;
    end
  endtask

  initial begin
    bit          h;
    logic [1:0]  sel;
    logic [31:0] tgt;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    exp_pc = RESET_PC;
    idle_inputs();

    // Zero-wait first fetch: valid appears on the third cycle after reset release.
    do_reset();
    @(negedge clk);
    check("first_req",  bus.imem_req_o,  1);
    check("first_addr", bus.imem_addr_o, 32'h0);
    bus.imem_gnt_i = 1'b1;
    @(negedge clk);
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0000_0013;
    check("first_c2_valid", bus.instr_valid_o, 0);
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    check("first_c3_valid", bus.instr_valid_o, 1);
    check("first_c3_pc",    bus.pc_o,          32'h0);
    check("first_c3_instr", bus.instr_o,       32'h0000_0013);
    bus.instr_ready_i = 1'b1;
    bus.next_sel_i    = 2'd0;
    @(negedge clk);
    idle_inputs();
    exp_pc = 32'h4;
    check("first_next", bus.imem_addr_o, 32'h4);

    // Sequential stream 0x4, 0x8, 0xC.
    repeat (3) fetch_one(0, 0, 0, 2'd0, 1'b0, 32'd0, $urandom, h);
    check("seq_pc", exp_pc, 32'h10);

    // Branch at 0x100: not taken then taken (second fetch at 0x104).
    fetch_one(0, 0, 0, 2'd2, 1'b0, 32'h100, $urandom, h);
    fetch_one(0, 0, 0, 2'd3, 1'b0, 32'h200, $urandom, h);
    check("br_not_taken", exp_pc, 32'h104);
    fetch_one(0, 0, 0, 2'd3, 1'b1, 32'h200, $urandom, h);
    check("br_taken", exp_pc, 32'h200);

    // Backpressure 5 cycles and grant delayed 3 cycles; then wrap at the top of memory.
    fetch_one(3, 1, 5, 2'd2, 1'b0, 32'hFFFF_FFFC, $urandom, h);
    fetch_one(0, 0, 0, 2'd0, 1'b0, 32'd0, $urandom, h);
    check("wrap_pc", exp_pc, 32'h0);

    // Randomized fetches with aligned targets.
    for (int i = 0; i < 40; i++) begin
      sel = 2'($urandom_range(0, 3));
      tgt = $urandom & 32'hFFFF_FFFC;
      if (sel == 2'd1) tgt = tgt | 32'($urandom_range(0, 1));
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                sel, 1'($urandom_range(0, 1)), tgt, $urandom, h);
      check("rand_no_halt", 32'(h), 0);
    end

    // Reset while waiting for data; the late rvalid must be ignored.
    do_reset();
    grant_phase(0);
    rst_n = 1'b0;
    #1;
    check("midrst_req",   bus.imem_req_o,    0);
    check("midrst_pc",    bus.pc_o,          RESET_PC);
    check("midrst_valid", bus.instr_valid_o, 0);
    @(negedge clk);
    rst_n             = 1'b1;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      check("stale_valid", bus.instr_valid_o, 0);
      check("stale_addr",  bus.imem_addr_o,   RESET_PC);
    end
    bus.imem_rvalid_i = 1'b0;
    exp_pc = RESET_PC;
    fetch_one(1, 0, 0, 2'd0, 1'b0, 32'd0, 32'h1234_5678, h);
    check("refetch_pc", exp_pc, RESET_PC + 32'd4);

    // jalr to 0x1003 -> 0x1002, misaligned: pulse then halt.
    fetch_one(0, 0, 0, 2'd1, 1'b0, 32'h0000_1003, $urandom, h);
    check("jalr_halted", 32'(h), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
